// File: rtl/spi_slave_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_frame_ctrl
//  Description : SPI slave front end for the single-port command RAM.
//                Deserialises MOSI frames of DATA_W+2 bits {op[1:0], payload}
//                into rx_data with a one-cycle rx_valid strobe. After a
//                read-data frame it waits for the RAM reply (tx_data/tx_valid)
//                and shifts the word out on MISO, MSB first.
//  Ports       : clk, rst        - system/SPI bit clock, sync active-high reset
//                ss_n, mosi      - slave select (active-low), serial command in
//                miso            - serial read data out, 0 when idle
//                rx_data/rx_valid- assembled command and strobe to the RAM
//                tx_data/tx_valid- read word and strobe from the RAM
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_frame_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int FW  = DATA_W + 2;
    localparam int BCW = $clog2(FW + 1);
    localparam int TCW = $clog2(DATA_W + 1);

    localparam logic [BCW-1:0] C_LAST_BIT = BCW'(FW - 1);
    localparam logic [TCW-1:0] C_TX_BITS  = TCW'(DATA_W);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CHK_CMD   = 3'd1;
    localparam logic [2:0] S_WRITE     = 3'd2;
    localparam logic [2:0] S_READ_ADD  = 3'd3;
    localparam logic [2:0] S_READ_DATA = 3'd4;
    localparam logic [2:0] S_SEND      = 3'd5;
    localparam logic [2:0] S_WAIT_END  = 3'd6;

    logic [2:0]        state_q,        state_d;
    logic [FW-1:0]     shift_q,        shift_d;
    logic [BCW-1:0]    bit_cnt_q,      bit_cnt_d;
    logic [FW-1:0]     rx_data_q,      rx_data_d;
    logic              rx_valid_q,     rx_valid_d;
    logic              miso_q,         miso_d;
    logic              rd_addr_seen_q, rd_addr_seen_d;
    logic [DATA_W-1:0] tx_shift_q,     tx_shift_d;
    logic              tx_active_q,    tx_active_d;
    logic [TCW-1:0]    tx_cnt_q,       tx_cnt_d;

    // Frame bit shifted in this cycle; only meaningful in receive states.
    logic [FW-1:0]     shift_next;
    assign shift_next = {shift_q[FW-2:0], mosi};

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        miso_d         = miso_q;
        rd_addr_seen_d = rd_addr_seen_q;
        tx_shift_d     = tx_shift_q;
        tx_active_d    = tx_active_q;
        tx_cnt_d       = tx_cnt_q;

        // Deselect wins over everything: partial frames and SENDs are dropped
        // without touching rx_data or rd_addr_seen.
        if (state_q != S_IDLE && ss_n) begin
            state_d     = S_IDLE;
            miso_d      = 1'b0;
            tx_active_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    miso_d = 1'b0;
                    if (!ss_n) begin
                        state_d   = S_CHK_CMD;
                        bit_cnt_d = '0;
                    end
                end

                S_CHK_CMD: begin
                    shift_d   = shift_next;
                    bit_cnt_d = BCW'(1);
                    if (!mosi)
                        state_d = S_WRITE;
                    else if (!rd_addr_seen_q)
                        state_d = S_READ_ADD;
                    else
                        state_d = S_READ_DATA;
                end

                S_WRITE, S_READ_ADD, S_READ_DATA: begin
                    shift_d = shift_next;
                    if (bit_cnt_q == C_LAST_BIT) begin
                        rx_data_d  = shift_next;
                        rx_valid_d = 1'b1;
                        if (state_q == S_READ_DATA) begin
                            state_d        = S_SEND;
                            rd_addr_seen_d = 1'b0;
                            tx_active_d    = 1'b0;
                        end else begin
                            state_d = S_WAIT_END;
                            if (state_q == S_READ_ADD)
                                rd_addr_seen_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end

                S_SEND: begin
                    if (!tx_active_q) begin
                        if (tx_valid) begin
                            miso_d      = tx_data[DATA_W-1];
                            tx_shift_d  = {tx_data[DATA_W-2:0], 1'b0};
                            tx_active_d = 1'b1;
                            tx_cnt_d    = TCW'(1);
                        end
                    end else if (tx_cnt_q == C_TX_BITS) begin
                        // Last bit has had its cycle on the pin.
                        miso_d      = 1'b0;
                        tx_active_d = 1'b0;
                        state_d     = S_WAIT_END;
                    end else begin
                        miso_d     = tx_shift_q[DATA_W-1];
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                        tx_cnt_d   = tx_cnt_q + TCW'(1);
                    end
                end

                S_WAIT_END: begin
                    miso_d = 1'b0;
                end

                default: begin
                    state_d = S_IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            miso_q         <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_shift_q     <= '0;
            tx_active_q    <= 1'b0;
            tx_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            miso_q         <= miso_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            tx_shift_q     <= tx_shift_d;
            tx_active_q    <= tx_active_d;
            tx_cnt_q       <= tx_cnt_d;
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_frame_ctrl
//  Description : Self-checking bench for spi_slave_frame_ctrl. Directed frames
//                drive the pins; a frame-level model tracks what rx_data,
//                rx_valid and miso must be and whether a read address is
//                pending; a negedge process compares every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [9:0] exp_rx_data  = '0;
    logic       exp_rx_valid = 1'b0;
    logic       exp_miso     = 1'b0;
    bit         rd_seen      = 1'b0;
    bit         check_en     = 1'b0;
    logic [7:0] cap;

    spi_slave_frame_ctrl #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("miso",     {31'd0, miso},     {31'd0, exp_miso});
            chk("rx_valid", {31'd0, rx_valid}, {31'd0, exp_rx_valid});
            chk("rx_data",  {22'd0, rx_data},  {22'd0, exp_rx_data});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One SPI transaction. nbits<10 deselects before the frame completes.
    // A tx_valid reply with txd is offered after every completed frame; only
    // a read-data frame may turn it into MISO traffic. spur injects a
    // tx_valid of 8'hFF mid-frame. send_abort>0 deselects after that many
    // MISO bits.
    task automatic frame(input logic [9:0] f, input int nbits, input logic [9:0] lit,
                         input logic [7:0] txd, input bit spur, input int send_abort,
                         output logic [7:0] got);
        bit is_rd;
        bit aborted;
        got = 8'h00;
        ss_n = 1'b0;
        tick;
        for (int i = 0; i < nbits; i++) begin
            mosi = f[9-i];
            if (spur && i == 4) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end
            tick;
            tx_valid = 1'b0;
        end
        if (nbits < 10) begin
            ss_n = 1'b1;
            mosi = 1'b0;
            tick;
        end else begin
            exp_rx_valid = 1'b1;
            exp_rx_data  = f;
            chk("lit_rx_data", {22'd0, rx_data}, {22'd0, lit});
            chk("lit_rx_valid", {31'd0, rx_valid}, 32'd1);
            is_rd = 1'b0;
            if (f[9]) begin
                is_rd   = rd_seen;
                rd_seen = !rd_seen;
            end
            mosi     = 1'b0;
            tx_data  = txd;
            tx_valid = 1'b1;
            tick;
            exp_rx_valid = 1'b0;
            tx_valid     = 1'b0;
            if (is_rd) begin
                exp_miso = txd[7];
                got = {got[6:0], miso};
                aborted = 1'b0;
                for (int b = 6; b >= 0; b--) begin
                    if (!aborted) begin
                        if (send_abort > 0 && (7 - b) == send_abort) begin
                            ss_n = 1'b1;
                            tick;
                            exp_miso = 1'b0;
                            aborted  = 1'b1;
                        end else begin
                            if (b == 4) begin
                                tx_valid = 1'b1;
                                tx_data  = ~txd;
                            end
                            tick;
                            tx_valid = 1'b0;
                            exp_miso = txd[b];
                            got = {got[6:0], miso};
                        end
                    end
                end
                if (!aborted) begin
                    tick;
                    exp_miso = 1'b0;
                end
            end else begin
                tick;
                tick;
            end
            ss_n = 1'b1;
            tick;
        end
    endtask

    initial begin
        tick;
        check_en = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        tick;

        // Write address and write data
        frame(10'b00_1010_0101, 10, 10'h0A5, 8'h81, 1'b0, 0, cap);
        frame(10'b01_0011_1100, 10, 10'h13C, 8'h81, 1'b0, 0, cap);
        // Read address then read data with RAM reply C3
        frame(10'b10_0000_0111, 10, 10'h207, 8'h81, 1'b0, 0, cap);
        frame(10'b11_0000_0000, 10, 10'h300, 8'hC3, 1'b0, 0, cap);
        chk("lit_miso_word", {24'd0, cap}, 32'h0000_00C3);
        // Abort a read-address frame after 5 bits; next one is still READ_ADD
        frame(10'b10_0000_0111, 5, 10'h000, 8'h81, 1'b0, 0, cap);
        frame(10'b10_0000_0111, 10, 10'h207, 8'h81, 1'b0, 0, cap);
        // Write with a spurious tx_valid mid-frame
        frame(10'b00_1010_0101, 10, 10'h0A5, 8'hFF, 1'b1, 0, cap);
        // Read data after pending address, with a second tx_valid while shifting
        frame(10'b11_1010_1010, 10, 10'h3AA, 8'h5A, 1'b0, 0, cap);
        chk("lit_miso_word2", {24'd0, cap}, 32'h0000_005A);
        // Deselect on the edge of the final bit: discarded
        frame(10'b10_1111_1111, 9, 10'h000, 8'h81, 1'b0, 0, cap);
        frame(10'b10_1111_1111, 10, 10'h2FF, 8'h81, 1'b0, 0, cap);

        // Reset mid-frame: clears outputs and the pending read address
        ss_n = 1'b0;
        tick;
        mosi = 1'b1; tick;
        mosi = 1'b1; tick;
        mosi = 1'b0; tick;
        rst = 1'b1;
        tick;
        exp_rx_data  = '0;
        exp_rx_valid = 1'b0;
        exp_miso     = 1'b0;
        rd_seen      = 1'b0;
        tick;
        rst  = 1'b0;
        ss_n = 1'b1;
        mosi = 1'b0;
        tick;
        frame(10'b11_1100_0000, 10, 10'h3C0, 8'h81, 1'b0, 0, cap);

        // Deselect during SEND after 3 bits of F0
        frame(10'b11_0000_0001, 10, 10'h301, 8'hF0, 1'b0, 3, cap);
        chk("lit_miso_part", {24'd0, cap}, 32'h0000_0007);
        frame(10'b11_1111_1111, 10, 10'h3FF, 8'h81, 1'b0, 0, cap);
        tick;
        tick;

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
